// File: rtl/levenshtein_vector_loader_pkg.sv
// levenshtein_pkg: Wishbone constants, register map and vector-table addressing shared with the search controller
package levenshtein_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [4:0] REG_CTRL    = 5'h10;
    localparam logic [4:0] REG_STATUS  = 5'h11;
    localparam logic [4:0] REG_LENGTH  = 5'h12;
    // The table lives above bit (8 + byte bits): address = {1'b1, char, byte}
    localparam int VT_BASE_BIT = 8;
    function automatic logic [31:0] vt_addr(input logic [7:0] c, input logic [31:0] b, input int unsigned bb);
        return (32'd1 << (VT_BASE_BIT + bb)) | ({24'd0, c} << bb) | b;
    endfunction
endpackage

// File: rtl/levenshtein_vector_loader_if.sv
// levenshtein_vector_loader_if: 8-bit Wishbone bus
//   cyc/stb/we/adr/dat_w/cti/bte driven by the master; ack/err/rty/dat_r driven by the slave
interface levenshtein_vector_loader_if #(parameter int AW = 24);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [7:0]    dat_w;
    logic [7:0]    dat_r;
    logic          ack;
    logic          err;
    logic          rty;
    logic [2:0]    cti;
    logic [1:0]    bte;
    modport master(output cyc, stb, we, adr, dat_w, cti, bte, input ack, err, rty, dat_r);
    modport slave(input cyc, stb, we, adr, dat_w, output dat_r, ack, err, rty);
endinterface

// File: rtl/levenshtein_vector_loader_pm_vector.sv
// levenshtein_pm_vector: Myers match vector for one character
//   char_i: character code; word_i: word bytes (byte 0 first); len_i: length-1; vec_o: bit i set when word[i]==char and i<=len
module levenshtein_pm_vector #(
    parameter int W  = 16,
    parameter int LW = $clog2(W)
) (
    input  logic [7:0]        char_i,
    input  logic [W-1:0][7:0] word_i,
    input  logic [LW-1:0]     len_i,
    output logic [W-1:0]      vec_o
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign vec_o[i] = word_i[i] == char_i && i <= int'(len_i);
    end
endmodule

// File: rtl/levenshtein_vector_loader.sv
// levenshtein_vector_loader: writes the 256-entry Myers bitvector table to SRAM from a host-supplied word
//   clk_i/rst_ni: clock, async active-low reset
//   wbs: register slave (word bytes 0x00-0x0F, CTRL 0x10, STATUS 0x11, LENGTH 0x12)
//   wbm: table write master; busy_o: build in progress; done_o: one-cycle completion pulse
module levenshtein_vector_loader
    import levenshtein_pkg::*;
#(
    parameter int MASTER_ADDR_WIDTH = 24,
    parameter int SLAVE_ADDR_WIDTH  = 24,
    parameter int BITVECTOR_WIDTH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    levenshtein_vector_loader_if.slave  wbs,
    levenshtein_vector_loader_if.master wbm,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int NB = BITVECTOR_WIDTH / 8;
    localparam int BB = NB > 1 ? $clog2(NB) : 0;
    localparam int BW = NB > 1 ? BB : 1;
    localparam int LW = $clog2(BITVECTOR_WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BEAT = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]                      state_q, state_d;
    logic [7:0]                      c_q, c_d;
    logic [BW-1:0]                   b_q, b_d;
    logic [BITVECTOR_WIDTH-1:0][7:0] word_q, word_d;
    logic [LW-1:0]                   len_q, len_d;
    logic                            done_q, done_d, err_q, err_d, ack_q;
    logic                            req, wr, start, beat, last, word_sel;
    logic [4:0]                      ra;
    logic [BITVECTOR_WIDTH-1:0]      vec;
    logic                            unused;

    assign ra       = wbs.adr[4:0];
    assign req      = wbs.cyc && wbs.stb && !ack_q;
    // Configuration is frozen during a build; such writes are still acked
    assign wr       = req && wbs.we && !busy_o;
    assign start    = wr && ra == REG_CTRL && wbs.dat_w[0];
    assign word_sel = !ra[4] && int'(ra) < BITVECTOR_WIDTH;
    assign beat     = state_q == S_BEAT;
    assign last     = b_q == BW'(NB - 1);
    assign busy_o   = state_q != S_IDLE;
    assign done_o   = state_q == S_FIN;
    assign unused   = ^{wbs.adr[SLAVE_ADDR_WIDTH-1:5], wbm.dat_r};

    levenshtein_pm_vector #(.W(BITVECTOR_WIDTH)) u_pm (
        .char_i(c_q),
        .word_i(word_q),
        .len_i (len_q),
        .vec_o (vec)
    );

    always_comb begin
        word_d = word_q;
        len_d  = len_q;
        if (wr && word_sel) word_d[ra[3:0]] = wbs.dat_w;
        if (wr && ra == REG_LENGTH) len_d = wbs.dat_w[LW-1:0];
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        b_d     = b_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_BEAT;
                c_d     = '0;
                b_d     = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            S_BEAT: if (wbm.err || wbm.rty) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else if (wbm.ack) begin
                b_d = b_q + 1'b1;
                if (last) state_d = c_q == 8'hFF ? S_FIN : S_GAP;
            end
            S_GAP: begin
                state_d = S_BEAT;
                c_d     = c_q + 1'b1;
                b_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            b_q     <= '0;
            word_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            b_q     <= b_d;
            word_q  <= word_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ack_q   <= req;
        end
    end

    assign wbs.ack   = ack_q;
    assign wbs.err   = 1'b0;
    assign wbs.rty   = 1'b0;
    assign wbs.dat_r = word_sel ? word_q[ra[3:0]] :
                       ra == REG_STATUS ? {5'd0, err_q, done_q, busy_o} :
                       ra == REG_LENGTH ? 8'(len_q) : 8'h00;

    assign wbm.cyc   = beat;
    assign wbm.stb   = beat;
    assign wbm.we    = 1'b1;
    assign wbm.adr   = beat ? MASTER_ADDR_WIDTH'(vt_addr(c_q, 32'(b_q), BB)) : '0;
    // Byte 0 carries the top vector bits, so the vector is stored big-endian
    assign wbm.dat_w = beat ? 8'(vec >> (8 * (NB - 1 - int'(b_q)))) : 8'h00;
    assign wbm.cti   = !beat || NB == 1 ? CTI_CLASSIC : last ? CTI_EOB : CTI_INCR;
    assign wbm.bte   = BTE_LINEAR;
endmodule

// File: tb/tb_levenshtein_vector_loader.sv
// tb_levenshtein_vector_loader: directed tests with a beat-sequence model and an SRAM image check
module tb_levenshtein_vector_loader;
    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
        logic [2:0]  t;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done;
    always #5 clk = ~clk;

    levenshtein_vector_loader_if #(.AW(24)) wbs_bus();
    levenshtein_vector_loader_if #(.AW(24)) wbm_bus();

    levenshtein_vector_loader dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .wbs   (wbs_bus),
        .wbm   (wbm_bus),
        .busy_o(busy),
        .done_o(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    int last_cnt = 0;
    int t_start = 0;
    int done_n = 0;
    int done_cyc = 0;
    int ws = 0;
    int wcnt = 0;
    logic err_arm = 1'b0;
    logic [23:0] err_adr = '0;
    logic mem_clr = 1'b0;
    logic [7:0] mem [0:1023];
    logic [7:0] tw [16];
    int tl = 0;
    beat_t exp_q[$];
    logic chk_en = 1'b0;
    logic seen_beat = 1'b0;
    logic err_prev = 1'b0;
    int gap = 0;
    logic [7:0] rd;

    assign wbs_bus.cti = 3'b000;
    assign wbs_bus.bte = 2'b00;
    assign wbm_bus.rty = 1'b0;
    assign wbm_bus.dat_r = 8'h00;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SRAM slave with programmable wait states and one injectable error address
    always_comb begin
        wbm_bus.err = err_arm && wbm_bus.stb && wbm_bus.adr == err_adr;
        wbm_bus.ack = wbm_bus.stb && !wbm_bus.err && wcnt >= ws;
    end
    always @(posedge clk) wcnt <= (wbm_bus.stb && !wbm_bus.ack) ? wcnt + 1 : 0;
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 1024; i++) mem[i] <= 8'hAA;
        else if (wbm_bus.stb && wbm_bus.ack) mem[wbm_bus.adr[9:0]] <= wbm_bus.dat_w;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_vec(input int c);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i <= tl; i++) if (int'(tw[i]) == c) v[i] = 1'b1;
        return v;
    endfunction

    task automatic load_model();
        logic [15:0] v;
        exp_q.delete();
        for (int c = 0; c < 256; c++) begin
            v = exp_vec(c);
            exp_q.push_back('{24'h200 | 24'(c << 1), v[15:8], 3'b010});
            exp_q.push_back('{24'h201 | 24'(c << 1), v[7:0], 3'b111});
        end
        seen_beat = 1'b0;
        gap = 0;
        chk_en = 1'b1;
    endtask

    // Every master cycle is checked against the head of the expected beat list
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            if (err_prev) chk("err_cyc_drop", wbm_bus.cyc, 0);
            if (wbm_bus.cyc) begin
                if (seen_beat && gap != 0) chk("gap_len", gap, 1);
                gap = 0;
                seen_beat = 1'b1;
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else begin
                    chk("beat_adr", wbm_bus.adr, exp_q[0].a);
                    chk("beat_dat", wbm_bus.dat_w, exp_q[0].d);
                    chk("beat_cti", wbm_bus.cti, exp_q[0].t);
                    chk("beat_stb_we", {wbm_bus.stb, wbm_bus.we, wbm_bus.bte}, 4'b1100);
                    if (wbm_bus.ack) void'(exp_q.pop_front());
                end
                if (wbm_bus.err) exp_q.delete();
            end else if (seen_beat) gap++;
            err_prev = wbm_bus.cyc && wbm_bus.err;
        end
        if (rst_n && done) begin
            done_n++;
            done_cyc = cyc_cnt;
        end
    end

    task automatic xfer(input logic w, input logic [4:0] a, input logic [7:0] d, output logic [7:0] q);
        int n;
        @(posedge clk); #1;
        wbs_bus.cyc = 1'b1;
        wbs_bus.stb = 1'b1;
        wbs_bus.we = w;
        wbs_bus.adr = {19'd0, a};
        wbs_bus.dat_w = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wbs_bus.ack && n < 20);
        last_cnt = cyc_cnt;
        q = wbs_bus.dat_r;
        chk($sformatf("ack_latency_%02h", a), n, 1);
        wbs_bus.cyc = 1'b0;
        wbs_bus.stb = 1'b0;
        wbs_bus.we = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        logic [7:0] q;
        xfer(1'b1, a, d, q);
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [7:0] e);
        logic [7:0] q;
        xfer(1'b0, a, 8'h00, q);
        chk(nm, q, e);
    endtask

    task automatic start_build();
        wr(5'h10, 8'h01);
        t_start = last_cnt;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, n < 5000, 1);
    endtask

    task automatic clear_mem();
        mem_clr = 1'b1;
        @(posedge clk); #1;
        mem_clr = 1'b0;
    endtask

    task automatic chk_table(input string nm);
        logic [15:0] v;
        for (int c = 0; c < 256; c++) begin
            v = exp_vec(c);
            chk($sformatf("%s_%02h", nm, c), {mem[10'h200 | 10'(c << 1)], mem[10'h201 | 10'(c << 1)]}, v);
        end
    endtask

    task automatic chk_reset_outputs(input string p);
        chk({p, "_wbm_ctl"}, {wbm_bus.cyc, wbm_bus.stb, wbm_bus.we}, 3'b001);
        chk({p, "_wbm_adr"}, wbm_bus.adr, 0);
        chk({p, "_wbm_dat"}, wbm_bus.dat_w, 0);
        chk({p, "_wbm_cti_bte"}, {wbm_bus.cti, wbm_bus.bte}, 0);
        chk({p, "_wbs_resp"}, {wbs_bus.ack, wbs_bus.err, wbs_bus.rty}, 0);
        chk({p, "_busy_done"}, {busy, done}, 0);
    endtask

    initial begin
        int d0;
        wbs_bus.cyc = 1'b0;
        wbs_bus.stb = 1'b0;
        wbs_bus.we = 1'b0;
        wbs_bus.adr = 24'h11;
        wbs_bus.dat_w = 8'h00;
        for (int i = 0; i < 16; i++) tw[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        chk("rst_status_comb", wbs_bus.dat_r, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_chk("rst_length", 5'h12, 8'h00);

        // Word "ab", LENGTH=1, zero-wait slave
        wr(5'h00, "a");
        wr(5'h01, "b");
        wr(5'h12, 8'h01);
        rd_chk("word_rb1", 5'h01, "b");
        tw[0] = "a";
        tw[1] = "b";
        tl = 1;
        chk("pin_ab_a", exp_vec(8'h61), 16'h0001);
        chk("pin_ab_b", exp_vec(8'h62), 16'h0002);
        clear_mem();
        load_model();
        start_build();
        wait_idle("ab");
        chk("ab_done_count", done_n, 1);
        chk("ab_build_cycles", done_cyc - t_start + 2, 769);
        chk("ab_beats_left", exp_q.size(), 0);
        chk("ab_mem_2c2", mem[10'h2C2], 8'h00);
        chk("ab_mem_2c3", mem[10'h2C3], 8'h01);
        chk("ab_mem_2c4", mem[10'h2C4], 8'h00);
        chk("ab_mem_2c5", mem[10'h2C5], 8'h02);
        chk_table("ab_tab");
        rd_chk("ab_status", 5'h11, 8'h02);

        // Word "aba" with a stale 'a' in byte 3, LENGTH=2, three wait states per beat
        wr(5'h02, "a");
        wr(5'h03, "a");
        wr(5'h12, 8'h02);
        tw[2] = "a";
        tw[3] = "a";
        tl = 2;
        chk("pin_aba_a", exp_vec(8'h61), 16'h0005);
        chk("pin_aba_b", exp_vec(8'h62), 16'h0002);
        ws = 3;
        clear_mem();
        load_model();
        start_build();
        wait_idle("aba");
        chk("aba_done_count", done_n, 2);
        chk("aba_beats_left", exp_q.size(), 0);
        chk("aba_mem_2c3", mem[10'h2C3], 8'h05);
        chk("aba_mem_2c5", mem[10'h2C5], 8'h02);
        chk_table("aba_tab");

        // Bus error on char 0x40 byte 1, then a clean restart
        ws = 0;
        err_arm = 1'b1;
        err_adr = 24'h281;
        load_model();
        start_build();
        wait_idle("err");
        chk("err_done_count", done_n, 2);
        rd_chk("err_status", 5'h11, 8'h04);
        err_arm = 1'b0;
        clear_mem();
        load_model();
        start_build();
        wait_idle("restart");
        chk("restart_done_count", done_n, 3);
        chk_table("restart_tab");
        rd_chk("restart_status", 5'h11, 8'h02);

        // START and configuration writes while busy are acked but have no effect
        clear_mem();
        load_model();
        start_build();
        repeat (50) @(posedge clk);
        wr(5'h10, 8'h01);
        wr(5'h00, "z");
        wr(5'h12, 8'h05);
        d0 = t_start;
        wait_idle("busy");
        chk("busy_done_count", done_n, 4);
        chk("busy_build_cycles", done_cyc - d0 + 2, 769);
        chk("busy_beats_left", exp_q.size(), 0);
        chk_table("busy_tab");
        rd_chk("busy_word0", 5'h00, "a");
        rd_chk("busy_length", 5'h12, 8'h02);

        // Asynchronous reset in the middle of a build
        load_model();
        start_build();
        for (int i = 0; i < 200 && cyc_cnt < t_start + 99; i++) @(posedge clk);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_chk("midrst_status", 5'h11, 8'h00);
        rd_chk("midrst_length", 5'h12, 8'h00);
        rd_chk("midrst_word0", 5'h00, 8'h00);
        chk("midrst_done_count", done_n, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
